post_output_transposer: RTL

POST_OUTPUT_TRANSPOSER -- requirements
Module: post_output_transposer

---
 rtl/post_output_transposer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/post_output_transposer.sv
// Drains up to six polynomials from eight coefficient banks into an AXI-Stream of 8-lane beats.
// Optional POST_OUTPUT_TLAST_PER_POLYN_EN: tlast on the last beat of every polynomial instead of only the final one.
module post_output_transposer #(
    parameter int DATA_WIDTH   = 39,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_obuf_reset,
    input  logic                    i_obuf_start,
    input  logic [2:0]              i_obuf_npolyn,
    output logic                    o_obuf_busy,
    output logic                    o_obuf_done,
    output logic [47:0]             o_obuf_rden,
    output logic [71:0]             o_obuf_addr,
    input  logic [8*DATA_WIDTH-1:0] i_obuf_data,
    output logic                    o_axis_tvalid,
    input  logic                    i_axis_tready,
    output logic [8*DATA_WIDTH-1:0] o_axis_tdata,
    output logic                    o_axis_tlast
);
    localparam int BEAT_W = 8 * DATA_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              poly_q, poly_last_q;
    logic [8:0]              coef_q;
    logic                    issue, final_read, beat_last, push, pop;
    logic [CNT_W-1:0]        inflight_q, count_q;
    logic [CNT_W:0]          credit_used;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [READ_LATENCY-1:0] vld_sr, last_sr;
    logic [BEAT_W:0]         fifo_mem [FIFO_DEPTH];
    logic [BEAT_W:0]         head;

    assign final_read  = (poly_q == poly_last_q) && (coef_q == 9'd511);
`ifdef POST_OUTPUT_TLAST_PER_POLYN_EN
    assign beat_last   = (coef_q == 9'd511);
`else
    assign beat_last   = final_read;
`endif
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign push        = vld_sr[READ_LATENCY-1];
    assign pop         = o_axis_tvalid & i_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Reads are credit-limited so every returning word is guaranteed a FIFO slot.
    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        o_obuf_busy = 1'b0;
        o_obuf_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_obuf_start)
                    state_d = (i_obuf_npolyn == 3'd0) ? DONE : READ;
            end
            READ: begin
                o_obuf_busy = 1'b1;
                if (credit_used < (CNT_W+1)'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (final_read) state_d = DRAIN;
                end
            end
            DRAIN: begin
                o_obuf_busy = 1'b1;
                if (count_q == '0 && inflight_q == '0) state_d = DONE;
            end
            DONE: begin
                o_obuf_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_obuf_reset) begin
            state_d     = IDLE;
            issue       = 1'b0;
            o_obuf_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poly_q      <= '0;
            coef_q      <= '0;
            poly_last_q <= '0;
        end else if (i_obuf_reset) begin
            poly_q <= '0;
            coef_q <= '0;
        end else if (state_q == IDLE && i_obuf_start) begin
            poly_q      <= '0;
            coef_q      <= '0;
            poly_last_q <= (i_obuf_npolyn >= 3'd6) ? 3'd5 : i_obuf_npolyn - 3'd1;
        end else if (issue) begin
            coef_q <= coef_q + 9'd1;
            if (coef_q == 9'd511) poly_q <= poly_q + 3'd1;
        end
    end

    always_comb begin
        o_obuf_rden = '0;
        o_obuf_addr = '0;
        if (issue) begin
            for (int b = 0; b < 8; b++) begin
                o_obuf_rden[b*6 + int'(poly_q)] = 1'b1;
                o_obuf_addr[b*9 +: 9]           = coef_q;
            end
        end
    end

    // Valid/last tags travel alongside the RAM latency; clearing them drops aborted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr     <= '0;
            last_sr    <= '0;
            inflight_q <= '0;
        end else if (i_obuf_reset) begin
            vld_sr     <= '0;
            last_sr    <= '0;
            inflight_q <= '0;
        end else begin
            vld_sr[0]  <= issue;
            last_sr[0] <= issue & beat_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_obuf_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !i_obuf_reset)
            fifo_mem[wr_ptr_q] <= {last_sr[READ_LATENCY-1], i_obuf_data};
    end

    assign head          = fifo_mem[rd_ptr_q];
    assign o_axis_tvalid = (count_q != '0);
    assign o_axis_tdata  = o_axis_tvalid ? head[BEAT_W-1:0] : '0;
    assign o_axis_tlast  = o_axis_tvalid & head[BEAT_W];

endmodule
